stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Parametrised successor to the single-output `timer`. It divides the system clock into a configurable sub-second tick and accumulates elapsed time as fraction, seconds and minutes. The block adds start/stop, clear, lap-freeze and a wrap/saturate mode. It sits between the debounced button front end and the seven-segment display driver.

## Interface
- `CLK_FREQ`, 10_000_000, input clock frequency in Hz.
- `TICK_HZ`, 100, ticks per second. Must be ≥2, and `CLK_FREQ % TICK_HZ == 0`.
- `MAX_MIN`, 60, number of minutes counted; minutes run 0..MAX_MIN-1. Must be ≥1.
- `WRAP_MODE`, 1. Value 1 wraps to zero at maximum; value 0 saturates and stops.
- `clk` in 1 — system clock, rising edge.
- `n_rst` in 1 — reset, asynchronous and active-low.
- `start_stop` in 1 — single-cycle pulse; toggles run/pause.
- `clear` in 1 — single-cycle pulse; zeroes everything and returns to IDLE.
- `lap` in 1 — single-cycle pulse; toggles the display freeze.
- `tick` out 1 — one-cycle pulse on every fraction increment.
- `disp_frac` out FRAC_W=$clog2(TICK_HZ) — displayed fraction, 0..TICK_HZ-1.
- `disp_sec` out 6 — displayed seconds, 0..59.
- `disp_min` out MIN_W=max(1,$clog2(MAX_MIN)) — displayed minutes.
- `running` out 1 — high in state RUNNING.
- `lap_hold` out 1 — display frozen.
- `wrapped` out 1 — sticky; set when the maximum count is reached.

## Operation
- DIV = CLK_FREQ/TICK_HZ. Prescaler `presc` counts 0..DIV-1, width $clog2(DIV).
- States: IDLE, RUNNING, PAUSED.
  - IDLE: counters are zero. `start_stop` moves to RUNNING.
  - RUNNING: `start_stop` moves to PAUSED.
  - PAUSED: `start_stop` moves back to RUNNING.
  - `clear` in any state moves to IDLE.
- Priority within one cycle: clear > start_stop > lap > count.
- RUNNING behaviour, per edge:
  - If `presc==DIV-1`, `presc` returns to 0, the time increments, and `tick` is registered high for one cycle.
  - Otherwise `presc` increments.
- Time increment rules:
  - frac wraps at TICK_HZ-1 and carries into sec.
  - sec wraps at 59 and carries into min.
  - At the maximum count (min=MAX_MIN-1, sec=59, frac=TICK_HZ-1):
    - WRAP_MODE=1: all fields go to 0 and `wrapped` is set to 1. Counting continues.
    - WRAP_MODE=0: counters hold at maximum, `wrapped` is set to 1, the state moves to PAUSED, and `start_stop` is ignored while `wrapped`=1.
- PAUSED: `presc` and counters hold, so resume keeps the sub-tick phase. `tick`=0.
- Display path:
  - When `lap_hold`=0, disp_* follow the internal counters in the same cycle (registered alongside them).
  - When `lap_hold`=1, disp_* keep the values captured at the edge `lap` was sampled. Internal counting continues.
- `lap` rules:
  - RUNNING: toggles `lap_hold`.
  - PAUSED: clears `lap_hold` only.
  - IDLE: ignored.
- `clear` zeroes `presc`, counters, disp_*, `tick`, `lap_hold` and `wrapped`.

## Timing
- Reset values: all outputs 0; state IDLE; `presc`=0.
- Start latency: `start_stop` sampled at edge E0 sets `running`=1 after E0. The first `tick` and disp_frac=1 are visible after edge E0+DIV.
- Tick spacing is exactly DIV cycles while RUNNING.
- Pause: a `start_stop` sampled at edge Ep halts counting from Ep. If Ep coincides with `presc==DIV-1`, the pause wins and no increment occurs.
- Resume: if the pause left `presc`=k, the next tick arrives DIV-k edges after the resume edge.
- `clear` takes effect at its sampling edge. A simultaneous `start_stop` is dropped and the state ends in IDLE.
- Asynchronous `n_rst` low mid-run forces all outputs to their reset values immediately, without waiting for a clock edge.
- Inputs are synchronous pulses; the upstream debouncer guarantees single-cycle width.

## Test plan
Unless noted, parameters are CLK_FREQ=20, TICK_HZ=4 (DIV=5), MAX_MIN=2.

1. Basic count:
   - Stimulus: reset, `start_stop` at E0.
   - Required: `tick` after E5, E10, E15, E20. After E20: disp_sec=1, disp_frac=0. Nothing asserts before E5.
2. Pause/resume:
   - Stimulus: start at E0, pause at E7 (presc=2, frac=1), idle 50 cycles, resume at E60.
   - Required: outputs unchanged and `tick`=0 while paused. Next tick after E63 with frac=2.
3. Lap:
   - Stimulus: running; `lap` at frac=2, sec=0; 40 cycles later `lap` again.
   - Required: disp_* hold 0:00.2 during the hold. On release, disp_* show 0:02.2 (internal value advanced by 8 ticks). `lap_hold` is 1 only during the hold.
4. Wrap (WRAP_MODE=1):
   - Stimulus: run 2400 edges.
   - Required: after the 2400th edge all disp_* are 0, `wrapped`=1, `running`=1.
5. Saturate (WRAP_MODE=0):
   - Stimulus: run until the maximum count, then pulse `start_stop`.
   - Required: disp shows 1:59.3, `running`=0, `wrapped`=1, and `start_stop` has no effect. After `clear`: all 0, state IDLE.
6. Clear and reset:
   - Stimulus: `clear` and `start_stop` in the same cycle while running.
   - Required: IDLE with all outputs 0.
   - Stimulus: drop `n_rst` between clock edges mid-run.
   - Required: all outputs 0 before the next edge.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch: divides clk into TICK_HZ ticks and accumulates min:sec.frac.
// Supports run/pause, clear, lap display freeze, and wrap or saturate at full scale.
module stopwatch_counter #(
  parameter  int CLK_FREQ  = 10_000_000,
  parameter  int TICK_HZ   = 100,
  parameter  int MAX_MIN   = 60,
  parameter  int WRAP_MODE = 1,
  localparam int FRAC_W    = $clog2(TICK_HZ),
  localparam int MIN_W     = (MAX_MIN > 1) ? $clog2(MAX_MIN) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic              tick,
  output logic [FRAC_W-1:0] disp_frac,
  output logic [5:0]        disp_sec,
  output logic [MIN_W-1:0]  disp_min,
  output logic              running,
  output logic              lap_hold,
  output logic              wrapped
);

  localparam int DIV     = CLK_FREQ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [FRAC_W-1:0]  FRAC_LAST  = FRAC_W'(TICK_HZ - 1);
  localparam logic [5:0]         SEC_LAST   = 6'd59;
  localparam logic [MIN_W-1:0]   MIN_LAST   = MIN_W'(MAX_MIN - 1);
  localparam bit                 SATURATE   = (WRAP_MODE == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED
  } state_e;

  typedef struct packed {
    logic [MIN_W-1:0]  min;
    logic [5:0]        sec;
    logic [FRAC_W-1:0] frac;
  } elapsed_t;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  elapsed_t           cnt_q, cnt_d;
  elapsed_t           disp_q, disp_d;
  elapsed_t           cnt_inc;
  logic               tick_q, tick_d;
  logic               lap_hold_q, lap_hold_d;
  logic               wrapped_q, wrapped_d;
  logic               presc_last;
  logic               cnt_at_max;
  logic               resume_ok;

  assign presc_last = (presc_q == PRESC_LAST);
  assign cnt_at_max = (cnt_q.frac == FRAC_LAST) && (cnt_q.sec == SEC_LAST) &&
                      (cnt_q.min == MIN_LAST);
  // A saturated count can only be left through clear.
  assign resume_ok  = start_stop && !(SATURATE && wrapped_q);

  // Ripple-carry increment of frac -> sec -> min. Full scale rolls over to zero.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q.frac != FRAC_LAST) begin
      cnt_inc.frac = cnt_q.frac + 1'b1;
    end else begin
      cnt_inc.frac = '0;
      if (cnt_q.sec != SEC_LAST) begin
        cnt_inc.sec = cnt_q.sec + 1'b1;
      end else begin
        cnt_inc.sec = '0;
        cnt_inc.min = (cnt_q.min != MIN_LAST) ? cnt_q.min + 1'b1 : '0;
      end
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    lap_hold_d = lap_hold_q;
    wrapped_d  = wrapped_q;

    if (clear) begin
      state_d    = ST_IDLE;
      presc_d    = '0;
      cnt_d      = '0;
      lap_hold_d = 1'b0;
      wrapped_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (start_stop) begin
            // The prescaler still steps on the pause edge. Only the increment
            // that would have produced a tick is suppressed.
            state_d = ST_PAUSED;
            if (!presc_last) presc_d = presc_q + 1'b1;
          end else begin
            if (lap) lap_hold_d = !lap_hold_q;
            if (!presc_last) begin
              presc_d = presc_q + 1'b1;
            end else begin
              presc_d = '0;
              if (cnt_at_max && SATURATE) begin
                wrapped_d = 1'b1;
                state_d   = ST_PAUSED;
              end else begin
                cnt_d  = cnt_inc;
                tick_d = 1'b1;
                if (cnt_at_max) wrapped_d = 1'b1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (resume_ok)  state_d    = ST_RUNNING;
          else if (lap)   lap_hold_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The display tracks the counters unless a lap freeze is in force after this edge.
    disp_d = lap_hold_d ? disp_q : cnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so each register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      tick_q     <= 1'b0;
      lap_hold_q <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      tick_q     <= tick_d;
      lap_hold_q <= lap_hold_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign tick      = tick_q;
  assign disp_frac = disp_q.frac;
  assign disp_sec  = disp_q.sec;
  assign disp_min  = disp_q.min;
  assign running   = (state_q == ST_RUNNING);
  assign lap_hold  = lap_hold_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter. A wrapping instance and a
// saturating instance share one stimulus and are compared against an elapsed-tick model.
module tb_stopwatch_counter;

  localparam int CLK_FREQ = 20;
  localparam int TICK_HZ  = 4;
  localparam int MAX_MIN  = 2;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int TOTAL    = MAX_MIN * 60 * TICK_HZ;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;

  logic clk = 1'b0;
  logic n_rst, start_stop, clear, lap;

  logic       tick_w, running_w, lap_hold_w, wrapped_w;
  logic [1:0] disp_frac_w;
  logic [5:0] disp_sec_w;
  logic [0:0] disp_min_w;
  logic       tick_s, running_s, lap_hold_s, wrapped_s;
  logic [1:0] disp_frac_s;
  logic [5:0] disp_sec_s;
  logic [0:0] disp_min_s;

  logic [12:0] obs [2];

  int checks   = 0;
  int failures = 0;

  // Model state per instance: 0 = wrapping, 1 = saturating.
  int m_state   [2];
  int m_elapsed [2];
  int m_phase   [2];
  int m_disp    [2];
  bit m_tick    [2];
  bit m_hold    [2];
  bit m_wrapped [2];

  always #5 clk = ~clk;

  stopwatch_counter #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .WRAP_MODE(1)
  ) dut_wrap (
    .clk(clk), .n_rst(n_rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .tick(tick_w), .disp_frac(disp_frac_w), .disp_sec(disp_sec_w), .disp_min(disp_min_w),
    .running(running_w), .lap_hold(lap_hold_w), .wrapped(wrapped_w)
  );

  stopwatch_counter #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .WRAP_MODE(0)
  ) dut_sat (
    .clk(clk), .n_rst(n_rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .tick(tick_s), .disp_frac(disp_frac_s), .disp_sec(disp_sec_s), .disp_min(disp_min_s),
    .running(running_s), .lap_hold(lap_hold_s), .wrapped(wrapped_s)
  );

  assign obs[0] = {tick_w, running_w, lap_hold_w, wrapped_w, disp_min_w, disp_sec_w, disp_frac_w};
  assign obs[1] = {tick_s, running_s, lap_hold_s, wrapped_s, disp_min_s, disp_sec_s, disp_frac_s};

  function automatic logic [12:0] exp_vec(input int i);
    int d;
    d = m_disp[i];
    exp_vec = {m_tick[i], m_state[i] == S_RUN, m_hold[i], m_wrapped[i],
               1'(d / (TICK_HZ * 60)), 6'((d / TICK_HZ) % 60), 2'(d % TICK_HZ)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_elapsed[i] = 0; m_phase[i] = 0; m_disp[i] = 0;
      m_tick[i] = 1'b0; m_hold[i] = 1'b0; m_wrapped[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ss, input bit cl, input bit lp);
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 1'b0;
      if (cl) begin
        m_state[i] = S_IDLE; m_elapsed[i] = 0; m_phase[i] = 0;
        m_hold[i] = 1'b0; m_wrapped[i] = 1'b0;
      end else if (m_state[i] == S_IDLE) begin
        if (ss) m_state[i] = S_RUN;
      end else if (m_state[i] == S_RUN) begin
        if (ss) begin
          m_state[i] = S_PAUSE;
          if (m_phase[i] < DIV - 1) m_phase[i] = m_phase[i] + 1;
        end else begin
          if (lp) m_hold[i] = !m_hold[i];
          if (m_phase[i] < DIV - 1) begin
            m_phase[i] = m_phase[i] + 1;
          end else begin
            m_phase[i] = 0;
            if (m_elapsed[i] == TOTAL - 1) begin
              m_wrapped[i] = 1'b1;
              if (i == 1) m_state[i] = S_PAUSE;
              else begin m_elapsed[i] = 0; m_tick[i] = 1'b1; end
            end else begin
              m_elapsed[i] = m_elapsed[i] + 1;
              m_tick[i] = 1'b1;
            end
          end
        end
      end else begin
        if (ss && !(i == 1 && m_wrapped[i])) m_state[i] = S_RUN;
        else if (lp) m_hold[i] = 1'b0;
      end
      if (!m_hold[i]) m_disp[i] = m_elapsed[i];
    end
  endtask

  // One clock edge: inputs applied before the edge, outputs settled 1 time unit after it.
  task automatic step(input bit ss, input bit cl, input bit lp);
    start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_step(ss, cl, lp);
    #1;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 13'h0) begin
        failures++; $display("FAIL reset_low[%0d]: got %h want %h", i, obs[i], 13'h0);
      end
    end
    n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin
        failures++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_basic_count();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (running_w !== 1'b1) begin
      failures++; $display("FAIL basic_running: got %b want 1", running_w);
    end
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (tick_w !== (e % DIV == 0)) begin
        failures++; $display("FAIL basic_tick E%0d: got %b want %b", e, tick_w, e % DIV == 0);
      end
      if (e < DIV) begin
        checks++;
        if ({disp_min_w, disp_sec_w, disp_frac_w} !== 9'h0) begin
          failures++; $display("FAIL basic_early E%0d: got %h want 0", e, {disp_min_w, disp_sec_w, disp_frac_w});
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++; $display("FAIL basic_model[%0d] E%0d: got %h want %h", i, e, obs[i], exp_vec(i));
        end
      end
    end
    checks++;
    if (disp_sec_w !== 6'd1 || disp_frac_w !== 2'd0) begin
      failures++; $display("FAIL basic_E20: got sec=%0d frac=%0d want sec=1 frac=0", disp_sec_w, disp_frac_w);
    end
  endtask

  task automatic test_pause_resume();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 63; e++) begin
      step(e == 7 || e == 60, 1'b0, 1'b0);
      if (e >= 7 && e < 60) begin
        checks++;
        if (tick_w !== 1'b0 || running_w !== 1'b0 || disp_frac_w !== 2'd1 || disp_sec_w !== 6'd0) begin
          failures++; $display("FAIL pause_hold E%0d: got %h want frac=1 idle", e, obs[0]);
        end
      end
      if (e > 60) begin
        checks++;
        if (tick_w !== (e == 63)) begin
          failures++; $display("FAIL resume_tick E%0d: got %b want %b", e, tick_w, e == 63);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++; $display("FAIL pause_model[%0d] E%0d: got %h want %h", i, e, obs[i], exp_vec(i));
        end
      end
    end
    checks++;
    if (disp_frac_w !== 2'd2) begin
      failures++; $display("FAIL resume_frac: got %0d want 2", disp_frac_w);
    end
    // A pause on the edge that would tick suppresses that tick. The held phase
    // then ticks one edge after the resume.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (tick_w !== 1'b0 || disp_frac_w !== 2'd0 || running_w !== 1'b0) begin
      failures++; $display("FAIL pause_at_last: got %h want no tick, frac=0, paused", obs[0]);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (tick_w !== 1'b0) begin
      failures++; $display("FAIL resume_edge_tick: got %b want 0", tick_w);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (tick_w !== 1'b1 || disp_frac_w !== 2'd1) begin
      failures++; $display("FAIL resume_last_tick: got tick=%b frac=%0d want 1,1", tick_w, disp_frac_w);
    end
  endtask

  task automatic test_lap();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 52; e++) begin
      step(1'b0, 1'b0, e == 12 || e == 52);
      if (e >= 12 && e < 52) begin
        checks++;
        if (lap_hold_w !== 1'b1 || {disp_min_w, disp_sec_w, disp_frac_w} !== {1'b0, 6'd0, 2'd2}) begin
          failures++; $display("FAIL lap_hold E%0d: got %h want held 0:00.2", e, obs[0]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++; $display("FAIL lap_model[%0d] E%0d: got %h want %h", i, e, obs[i], exp_vec(i));
        end
      end
    end
    checks++;
    if (lap_hold_w !== 1'b0 || disp_sec_w !== 6'd2 || disp_frac_w !== 2'd2) begin
      failures++; $display("FAIL lap_release: got %h want 0:02.2 unheld", obs[0]);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (lap_hold_w !== 1'b0 || running_w !== 1'b0) begin
      failures++; $display("FAIL lap_idle: got hold=%b run=%b want 0,0", lap_hold_w, running_w);
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (lap_hold_w !== 1'b0 || disp_frac_w !== 2'd2 || running_w !== 1'b0) begin
      failures++; $display("FAIL lap_paused: got %h want unheld frac=2 paused", obs[0]);
    end
  endtask

  task automatic test_wrap_saturate();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 2400; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (e == 2399) begin
        checks++;
        if ({disp_min_w, disp_sec_w, disp_frac_w} !== {1'b1, 6'd59, 2'd3}) begin
          failures++; $display("FAIL wrap_max: got %h want 1:59.3", {disp_min_w, disp_sec_w, disp_frac_w});
        end
      end
      checks++;
      if (obs[0] !== exp_vec(0)) begin
        failures++; $display("FAIL wrap_model E%0d: got %h want %h", e, obs[0], exp_vec(0));
      end
    end
    checks++;
    if ({disp_min_w, disp_sec_w, disp_frac_w} !== 9'h0 || wrapped_w !== 1'b1 || running_w !== 1'b1) begin
      failures++; $display("FAIL wrap_end: got %h want zero, wrapped, running", obs[0]);
    end
    checks++;
    if ({disp_min_s, disp_sec_s, disp_frac_s} !== {1'b1, 6'd59, 2'd3} || wrapped_s !== 1'b1 || running_s !== 1'b0) begin
      failures++; $display("FAIL sat_end: got %h want 1:59.3, wrapped, stopped", obs[1]);
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (DIV + 1) step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({disp_min_s, disp_sec_s, disp_frac_s} !== {1'b1, 6'd59, 2'd3} || running_s !== 1'b0 || tick_s !== 1'b0) begin
      failures++; $display("FAIL sat_ignore_ss: got %h want 1:59.3 stopped", obs[1]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin
        failures++; $display("FAIL sat_model[%0d]: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 13'h0) begin
        failures++; $display("FAIL sat_clear[%0d]: got %h want 0", i, obs[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs[1] !== 13'h0) begin
      failures++; $display("FAIL sat_clear_idle: got %h want 0", obs[1]);
    end
  endtask

  task automatic test_clear_and_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 13'h0) begin
        failures++; $display("FAIL clear_ss[%0d]: got %h want 0", i, obs[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== 13'h0) begin
      failures++; $display("FAIL clear_stays_idle: got %h want 0", obs[0]);
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 13'h0) begin
        failures++; $display("FAIL async_reset[%0d]: got %h want 0", i, obs[i]);
      end
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== exp_vec(0)) begin
      failures++; $display("FAIL reset_release: got %h want %h", obs[0], exp_vec(0));
    end
  endtask

  task automatic test_random();
    int r;
    step(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      step(r < 6, r == 12, r >= 6 && r < 12);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++; $display("FAIL random[%0d] c%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_lap();
    test_wrap_saturate();
    test_clear_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
